// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state type and pointer helper for the 4:1 round-robin result arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Priority pointer after a grant: the requester just served drops to lowest priority.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for mux4_rr_arbiter; req_lock exists only with MUX4_ARB_LOCK_EN.
interface mux4_rr_arbiter_if
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           out_valid;
  logic [DATA_W-1:0]              out_data;
  logic [SEL_W-1:0]               out_src;
  logic                           out_ready;
`ifdef MUX4_ARB_LOCK_EN
  logic [NUM_REQ-1:0]             req_lock;
`endif

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready,
`ifdef MUX4_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, out_valid, out_data, out_src
  );

  // Requesters plus the downstream consumer.
  modport master (
    output req_valid, req_data, out_ready,
`ifdef MUX4_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority encoder: first set bit of req_i scanning from ptr_i upward, wrapping 3->0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   sel_o
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest offset down so the closest match to ptr_i wins.
  always_comb begin
    any_o = |req_i;
    sel_o = ptr_i;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + SEL_W'(k);
      if (req_i[idx]) begin
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 result arbiter with a one-word registered output slot.
// Optional grant locking is compiled in with MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RESET_PTR = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_rr_arbiter_if.slave      bus
);

  localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_PTR);

  state_t            state_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_src_q;

  logic [NUM_REQ-1:0] eff_req;
  logic               any;
  logic [SEL_W-1:0]   sel;
  logic               can_accept;
  logic               transfer;
  logic               lock_set;

`ifdef MUX4_ARB_LOCK_EN
  logic             locked_q;
  logic [SEL_W-1:0] owner_q;

  // While locked only the owner may compete, even when it is idle.
  assign eff_req  = locked_q ? (bus.req_valid & (NUM_REQ'(1) << owner_q)) : bus.req_valid;
  assign lock_set = bus.req_lock[sel];
`else
  assign eff_req  = bus.req_valid;
  assign lock_set = 1'b0;
`endif

  rr_pick4 u_pick (
    .req_i (eff_req),
    .ptr_i (ptr_q),
    .any_o (any),
    .sel_o (sel)
  );

  assign can_accept    = (state_q == EMPTY) | bus.out_ready;
  assign transfer      = rst_n & can_accept & any;
  assign bus.req_ready = transfer ? (NUM_REQ'(1) << sel) : '0;

  // Pointer holds while a lock is taken or kept.
  assign ptr_d = (transfer && !lock_set) ? next_ptr(sel) : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= RESET_SEL;
      out_data_q <= '0;
      out_src_q  <= '0;
`ifdef MUX4_ARB_LOCK_EN
      locked_q   <= 1'b0;
      owner_q    <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      unique case (state_q)
        EMPTY: if (transfer) state_q <= FULL;
        FULL:  if (bus.out_ready && !transfer) state_q <= EMPTY;
      endcase
      if (transfer) begin
        out_data_q <= bus.req_data[sel];
        out_src_q  <= sel;
`ifdef MUX4_ARB_LOCK_EN
        locked_q   <= lock_set;
        if (lock_set) owner_q <= sel;
`endif
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
